// File: rtl/rpdiag_seq_pkg.sv
// Shared definitions for the RP diagnostic field sequencer: state encoding,
// field-length defaults and the sector number width.
package rpdiag_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_ECC  = 2'd3
  } rpdiag_state_e;

  localparam int PRE_BITS_DEF   = 16;
  localparam int WORD_BITS_DEF  = 18;
  localparam int DATA_WORDS_DEF = 256;
  localparam int ECC_BITS_DEF   = 32;
  localparam int SECTORS_DEF    = 20;

  // Shared with the sector/track logic.
  localparam int SECT_W = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rpdiag_seq_edge.sv
// Rise detector for a software-toggled diagnostic level; the input is already
// in the clk domain, so only a history register is needed.
module rpdiag_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_kill,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_hist <= 1'b0;
    else if (i_kill) r_hist <= 1'b0;
    else             r_hist <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_hist;

endmodule

// File: rtl/rpdiag_seq.sv
// Diagnostic field sequencer: walks header, data and ECC fields from
// software-driven clocks and deserializes the data field into words.
module rpdiag_seq
  import rpdiag_seq_pkg::*;
#(
  parameter int PRE_BITS   = PRE_BITS_DEF,
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int DATA_WORDS = DATA_WORDS_DEF,
  parameter int ECC_BITS   = ECC_BITS_DEF,
  parameter int SECTORS    = SECTORS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 rpDMD,
  input  logic                 rpDCLK,
  input  logic                 rpDIND,
  input  logic                 rpDSCK,
  input  logic                 rpDDAT,
  output logic                 rpDFE,
  output logic                 rpECE,
  output logic [WORD_BITS-1:0] rpWORD,
  output logic                 rpWVAL,
  output logic [SECT_W-1:0]    rpSECT,
  output logic                 rpSKERR
);

  localparam int BCW = $clog2(max3(PRE_BITS, WORD_BITS, ECC_BITS));
  localparam int WCW = $clog2(DATA_WORDS) + 1;
  localparam logic [BCW-1:0]    PRE_LAST   = BCW'(PRE_BITS - 1);
  localparam logic [BCW-1:0]    WORD_LAST  = BCW'(WORD_BITS - 1);
  localparam logic [BCW-1:0]    ECC_LAST   = BCW'(ECC_BITS - 1);
  localparam logic [WCW-1:0]    WORDS_LAST = WCW'(DATA_WORDS - 1);
  localparam logic [SECT_W-1:0] SECT_LAST  = SECT_W'(SECTORS - 1);

  rpdiag_state_e        r_state, w_state_nxt;
  logic [BCW-1:0]       r_bitcnt, w_bitcnt_nxt;
  logic [WCW-1:0]       r_wordcnt, w_wordcnt_nxt;
  logic [WORD_BITS-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic [WORD_BITS-1:0] r_word, w_word_nxt;
  logic                 r_wval, w_wval_nxt;
  logic [SECT_W-1:0]    r_sect, w_sect_nxt;
  logic                 r_skerr, w_skerr_nxt;
  logic                 r_dfe, r_ece;
  logic                 w_kill, w_dclk_rise, w_dind_rise, w_dsck_rise;

  assign w_kill     = clr | ~rpDMD;
  assign w_shift_in = {r_shift[WORD_BITS-2:0], rpDDAT};

  rpdiag_edge u_edge_dclk (.clk(clk), .rst(rst), .i_kill(w_kill), .i_lvl(rpDCLK), .o_rise(w_dclk_rise));
  rpdiag_edge u_edge_dind (.clk(clk), .rst(rst), .i_kill(w_kill), .i_lvl(rpDIND), .o_rise(w_dind_rise));
  rpdiag_edge u_edge_dsck (.clk(clk), .rst(rst), .i_kill(w_kill), .i_lvl(rpDSCK), .o_rise(w_dsck_rise));

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_wordcnt_nxt = r_wordcnt;
    w_shift_nxt   = r_shift;
    w_word_nxt    = r_word;
    w_wval_nxt    = 1'b0;
    w_sect_nxt    = r_sect;
    w_skerr_nxt   = r_skerr;
    if (w_kill) begin
      w_state_nxt   = S_IDLE;
      w_bitcnt_nxt  = '0;
      w_wordcnt_nxt = '0;
      w_shift_nxt   = '0;
      w_word_nxt    = '0;
      w_sect_nxt    = '0;
      w_skerr_nxt   = 1'b0;
    end else begin
      if (w_dind_rise)      w_sect_nxt = '0;
      else if (w_dsck_rise) w_sect_nxt = (r_sect == SECT_LAST) ? '0 : r_sect + 1'b1;
      // A sector pulse restarts the field and swallows any coincident clock.
      if (w_dsck_rise) begin
        if (r_state != S_IDLE) w_skerr_nxt = 1'b1;
        w_state_nxt   = S_PRE;
        w_bitcnt_nxt  = '0;
        w_wordcnt_nxt = '0;
        w_shift_nxt   = '0;
      end else if (w_dclk_rise) begin
        case (r_state)
          S_PRE: begin
            if (r_bitcnt == PRE_LAST) begin
              w_state_nxt   = S_DATA;
              w_bitcnt_nxt  = '0;
              w_wordcnt_nxt = '0;
            end else begin
              w_bitcnt_nxt = r_bitcnt + 1'b1;
            end
          end
          S_DATA: begin
            w_shift_nxt = w_shift_in;
            if (r_bitcnt == WORD_LAST) begin
              w_word_nxt    = w_shift_in;
              w_wval_nxt    = 1'b1;
              w_bitcnt_nxt  = '0;
              w_wordcnt_nxt = r_wordcnt + 1'b1;
              if (r_wordcnt == WORDS_LAST) w_state_nxt = S_ECC;
            end else begin
              w_bitcnt_nxt = r_bitcnt + 1'b1;
            end
          end
          S_ECC: begin
            if (r_bitcnt == ECC_LAST) begin
              w_state_nxt  = S_IDLE;
              w_bitcnt_nxt = '0;
            end else begin
              w_bitcnt_nxt = r_bitcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_wordcnt <= '0;
      r_shift   <= '0;
      r_word    <= '0;
      r_wval    <= 1'b0;
      r_sect    <= '0;
      r_skerr   <= 1'b0;
      r_dfe     <= 1'b0;
      r_ece     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_wordcnt <= w_wordcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_word    <= w_word_nxt;
      r_wval    <= w_wval_nxt;
      r_sect    <= w_sect_nxt;
      r_skerr   <= w_skerr_nxt;
      r_dfe     <= (w_state_nxt == S_DATA);
      r_ece     <= (w_state_nxt == S_ECC);
    end
  end

  assign rpDFE   = r_dfe;
  assign rpECE   = r_ece;
  assign rpWORD  = r_word;
  assign rpWVAL  = r_wval;
  assign rpSECT  = r_sect;
  assign rpSKERR = r_skerr;

endmodule

// File: tb/tb_rpdiag_seq.sv
// Bench for rpdiag_seq: a position-in-sector reference model compared every
// cycle, directed field scenarios with literal expectations, then random stimulus.
module tb_rpdiag_seq;

  localparam int PRE   = 4;
  localparam int WB    = 18;
  localparam int NW    = 2;
  localparam int ECCB  = 8;
  localparam int NSECT = 20;
  localparam int DBITS = WB * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic rpDMD = 1'b0, rpDCLK = 1'b0, rpDIND = 1'b0, rpDSCK = 1'b0, rpDDAT = 1'b0;
  logic rpDFE, rpECE, rpWVAL, rpSKERR;
  logic [WB-1:0] rpWORD;
  logic [4:0]    rpSECT;

  int n_chk = 0;
  int n_err = 0;

  rpdiag_seq #(.PRE_BITS(PRE), .WORD_BITS(WB), .DATA_WORDS(NW), .ECC_BITS(ECCB), .SECTORS(NSECT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rpDMD(rpDMD), .rpDCLK(rpDCLK), .rpDIND(rpDIND),
    .rpDSCK(rpDSCK), .rpDDAT(rpDDAT), .rpDFE(rpDFE), .rpECE(rpECE), .rpWORD(rpWORD),
    .rpWVAL(rpWVAL), .rpSECT(rpSECT), .rpSKERR(rpSKERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position = DCLK rises counted since the last sector pulse
  // (-1 when no field is active); envelopes are ranges of that position.
  int          m_pos = -1;
  bit          m_pd = 0, m_pi = 0, m_ps = 0;
  int          m_sect = 0;
  bit          m_skerr = 0, m_wval = 0;
  logic [WB-1:0] m_word = '0;
  int          m_acc = 0, m_bits = 0;

  task automatic model_clear();
    m_pos = -1; m_pd = 0; m_pi = 0; m_ps = 0; m_sect = 0;
    m_skerr = 0; m_wval = 0; m_word = '0; m_acc = 0; m_bits = 0;
  endtask

  task automatic model_step();
    bit rd, ri, rs;
    if (clr || !rpDMD) begin
      model_clear();
    end else begin
      rd = rpDCLK && !m_pd; ri = rpDIND && !m_pi; rs = rpDSCK && !m_ps;
      m_pd = rpDCLK; m_pi = rpDIND; m_ps = rpDSCK;
      m_wval = 0;
      if (ri)      m_sect = 0;
      else if (rs) m_sect = (m_sect + 1) % NSECT;
      if (rs) begin
        if (m_pos >= 0) m_skerr = 1;
        m_pos = 0; m_acc = 0; m_bits = 0;
      end else if (rd && m_pos >= 0) begin
        if (m_pos >= PRE && m_pos < PRE + DBITS) begin
          m_acc = (m_acc << 1) | int'(rpDDAT);
          m_bits++;
          if (m_bits % WB == 0) begin
            m_word = m_acc[WB-1:0];
            m_acc  = 0;
            m_wval = 1;
          end
        end
        m_pos++;
        if (m_pos == PRE + DBITS + ECCB) m_pos = -1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_clear();
    else     model_step();
  end

  logic [WB-1:0] words[$];

  initial forever begin
    @(negedge clk);
    chk("dfe",   rpDFE,   (m_pos >= PRE && m_pos < PRE + DBITS));
    chk("ece",   rpECE,   (m_pos >= PRE + DBITS));
    chk("wval",  rpWVAL,  m_wval);
    chk("word",  rpWORD,  m_word);
    chk("sect",  rpSECT,  m_sect);
    chk("skerr", rpSKERR, m_skerr);
    if (rpWVAL) words.push_back(rpWORD);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dclk_pulse(input logic d);
    rpDDAT = d; rpDCLK = 1'b1; cyc(2);
    rpDCLK = 1'b0; cyc(2);
  endtask

  task automatic dsck_pulse();
    rpDSCK = 1'b1; cyc(2);
    rpDSCK = 1'b0; cyc(2);
  endtask

  task automatic dind_pulse();
    rpDIND = 1'b1; cyc(2);
    rpDIND = 1'b0; cyc(2);
  endtask

  task automatic send_word(input logic [WB-1:0] w);
    for (int i = WB - 1; i >= 0; i--) dclk_pulse(w[i]);
  endtask

  task automatic do_clr();
    clr = 1'b1; cyc(1);
    clr = 1'b0; cyc(1);
  endtask

  task automatic pre_clocks(input int n);
    for (int i = 0; i < n; i++) dclk_pulse(1'b0);
  endtask

  initial begin
    cyc(3);
    chk("reset_dfe",  rpDFE,  0);
    chk("reset_sect", rpSECT, 0);
    rst = 1'b0; rpDMD = 1'b1;
    cyc(2);

    // Full field
    words.delete();
    dsck_pulse();
    chk("full_sect1", rpSECT, 1);
    pre_clocks(PRE - 1);
    chk("full_dfe_pre", rpDFE, 0);
    pre_clocks(1);
    chk("full_dfe_on", rpDFE, 1);
    send_word(18'o252525);
    send_word(18'o707070);
    chk("full_dfe_off", rpDFE, 0);
    chk("full_ece_on",  rpECE, 1);
    chk("full_nwords",  words.size(), 2);
    chk("full_word0",   words[0], 18'o252525);
    chk("full_word1",   words[1], 18'o707070);
    pre_clocks(ECCB - 1);
    chk("full_ece_7", rpECE, 1);
    pre_clocks(1);
    chk("full_ece_off", rpECE, 0);
    chk("full_skerr",   rpSKERR, 0);
    dclk_pulse(1'b1);
    chk("full_idle_dfe", rpDFE, 0);

    // Sector wrap
    dind_pulse();
    chk("wrap_dind", rpSECT, 0);
    for (int i = 0; i < NSECT - 1; i++) dsck_pulse();
    chk("wrap_19", rpSECT, 19);
    dsck_pulse();
    chk("wrap_0", rpSECT, 0);
    do_clr();

    // Mid-field sector pulse
    dsck_pulse();
    pre_clocks(PRE);
    for (int i = 0; i < 5; i++) dclk_pulse(1'b1);
    chk("mid_dfe_before", rpDFE, 1);
    dsck_pulse();
    chk("mid_skerr", rpSKERR, 1);
    chk("mid_dfe",   rpDFE, 0);
    words.delete();
    pre_clocks(PRE);
    send_word(18'o123456);
    send_word(18'o654321);
    chk("mid_nwords", words.size(), 2);
    chk("mid_word0",  words[0], 18'o123456);
    chk("mid_word1",  words[1], 18'o654321);
    pre_clocks(ECCB);
    chk("mid_skerr_sticky", rpSKERR, 1);
    do_clr();
    chk("clr_skerr", rpSKERR, 0);

    // DMD drop mid-DATA
    dsck_pulse();
    pre_clocks(PRE);
    for (int i = 0; i < 5; i++) dclk_pulse(1'b1);
    rpDMD = 1'b0; cyc(1);
    chk("dmd_dfe",  rpDFE, 0);
    chk("dmd_sect", rpSECT, 0);
    chk("dmd_word", rpWORD, 0);
    dclk_pulse(1'b1);
    chk("dmd_dclk_dfe", rpDFE, 0);
    chk("dmd_dclk_ece", rpECE, 0);
    rpDMD = 1'b1; cyc(2);

    // Simultaneous DIND + DSCK
    dsck_pulse(); dsck_pulse();
    rpDIND = 1'b1; rpDSCK = 1'b1; cyc(2);
    rpDIND = 1'b0; rpDSCK = 1'b0; cyc(2);
    chk("sim_a_sect", rpSECT, 0);
    do_clr();

    // Simultaneous DCLK + DSCK: that clock must not count
    rpDCLK = 1'b1; rpDSCK = 1'b1; cyc(2);
    rpDCLK = 1'b0; rpDSCK = 1'b0; cyc(2);
    pre_clocks(PRE - 1);
    chk("sim_b_dfe_pre", rpDFE, 0);
    pre_clocks(1);
    chk("sim_b_dfe_on", rpDFE, 1);
    do_clr();

    // Asynchronous reset mid-ECC
    dsck_pulse();
    pre_clocks(PRE + DBITS + 3);
    chk("rst_ece_before", rpECE, 1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_ece_async", rpECE, 0);
    chk("rst_sect",      rpSECT, 0);
    chk("rst_word",      rpWORD, 0);
    chk("rst_dfe",       rpDFE, 0);
    cyc(2);
    rst = 1'b0; cyc(2);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rpDCLK = ~rpDCLK;
      rpDDAT = 1'($urandom_range(0, 1));
      rpDSCK = ($urandom_range(0, 499) == 0);
      rpDIND = ($urandom_range(0, 999) == 0);
      clr    = ($urandom_range(0, 1499) == 0);
      rpDMD  = ($urandom_range(0, 1999) != 0);
      cyc(1);
    end
    clr = 1'b0; rpDMD = 1'b1;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
